// File: rtl/target_display.sv
// target_display: renders N_TGT double-buffered square targets with blink control,
// reporting pixel coverage and the winning (lowest) target index two cycles later.
module target_display #(
    parameter int N_TGT = 4,
    parameter int SIZE = 48,
    parameter int BLINK_FRAMES = 15,
    localparam int IDX_W = (N_TGT > 1) ? $clog2(N_TGT) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [9:0]       h_cnt,
    input  logic [9:0]       v_cnt,
    input  logic             frame_start,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [9:0]       wr_x,
    input  logic [9:0]       wr_y,
    input  logic             wr_vis,
    input  logic             wr_blink,
    output logic             enable_target,
    output logic [IDX_W-1:0] target_idx,
    output logic             update_pending,
    output logic             blink_phase
);
    localparam int CW = $clog2(BLINK_FRAMES + 1);

    logic [9:0]       sx_q [N_TGT];
    logic [9:0]       sy_q [N_TGT];
    logic [9:0]       ax_q [N_TGT];
    logic [9:0]       ay_q [N_TGT];
    logic [N_TGT-1:0] svis_q, sblk_q, avis_q, ablk_q;
    logic [N_TGT-1:0] hit_d, hit_q, shown;
    logic [CW-1:0]    fcnt_q;
    logic             phase_q, pend_q, en_q, wr_ok, wrap;
    logic [IDX_W-1:0] idx_d, idx_q;

    assign wr_ok = wr_en && ({1'b0, wr_idx} < (IDX_W + 1)'(N_TGT));
    assign wrap  = fcnt_q == CW'(BLINK_FRAMES - 1);

    // 11-bit compares so a target running past 1023 clips instead of wrapping
    always_comb begin
        hit_d = '0;
        for (int i = 0; i < N_TGT; i++)
            hit_d[i] = ({1'b0, h_cnt} >= {1'b0, ax_q[i]}) && ({1'b0, h_cnt} < {1'b0, ax_q[i]} + 11'(SIZE)) &&
                       ({1'b0, v_cnt} >= {1'b0, ay_q[i]}) && ({1'b0, v_cnt} < {1'b0, ay_q[i]} + 11'(SIZE));
    end

    always_comb begin
        shown = hit_q & avis_q & (~ablk_q | {N_TGT{phase_q}});
        idx_d = '0;
        for (int i = N_TGT - 1; i >= 0; i--)
            if (shown[i]) idx_d = IDX_W'(i);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sx_q    <= '{default: '0};
            sy_q    <= '{default: '0};
            ax_q    <= '{default: '0};
            ay_q    <= '{default: '0};
            svis_q  <= '0;
            sblk_q  <= '0;
            avis_q  <= '0;
            ablk_q  <= '0;
            fcnt_q  <= '0;
            phase_q <= 1'b0;
            pend_q  <= 1'b0;
            hit_q   <= '0;
            en_q    <= 1'b0;
            idx_q   <= '0;
        end else begin
            if (frame_start) begin
                ax_q    <= sx_q;
                ay_q    <= sy_q;
                avis_q  <= svis_q;
                ablk_q  <= sblk_q;
                fcnt_q  <= wrap ? '0 : fcnt_q + CW'(1);
                phase_q <= phase_q ^ wrap;
            end
            if (wr_ok) begin
                sx_q[wr_idx]   <= wr_x;
                sy_q[wr_idx]   <= wr_y;
                svis_q[wr_idx] <= wr_vis;
                sblk_q[wr_idx] <= wr_blink;
            end
            pend_q <= wr_ok | (pend_q & ~frame_start);
            hit_q  <= hit_d;
            en_q   <= |shown;
            idx_q  <= idx_d;
        end
    end

    assign enable_target  = en_q;
    assign target_idx     = idx_q;
    assign update_pending = pend_q;
    assign blink_phase    = phase_q;
endmodule

// File: tb/tb_target_display.sv
// tb_target_display: directed self-checking bench for target_display (4 targets, 48 px, blink every 2 frames).
module tb_target_display;
    localparam int N = 4, S = 48, B = 2;

    logic       clk = 1'b0, rst = 1'b1;
    logic [9:0] h_cnt = '0, v_cnt = '0, wr_x = '0, wr_y = '0;
    logic       frame_start = 1'b0, wr_en = 1'b0, wr_vis = 1'b0, wr_blink = 1'b0;
    logic [1:0] wr_idx = '0;
    logic       enable_target, update_pending, blink_phase;
    logic [1:0] target_idx;
    int         errs = 0, checks = 0;

    target_display #(.N_TGT(N), .SIZE(S), .BLINK_FRAMES(B)) dut (
        .clk(clk), .rst(rst), .h_cnt(h_cnt), .v_cnt(v_cnt), .frame_start(frame_start),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_x(wr_x), .wr_y(wr_y), .wr_vis(wr_vis), .wr_blink(wr_blink),
        .enable_target(enable_target), .target_idx(target_idx),
        .update_pending(update_pending), .blink_phase(blink_phase)
    );

    always #5 clk = ~clk;

    task automatic wr(input logic [1:0] i, input int x, input int y, input logic vis, input logic blk, input logic fs);
        @(negedge clk);
        wr_en = 1'b1; wr_idx = i; wr_x = 10'(x); wr_y = 10'(y); wr_vis = vis; wr_blink = blk; frame_start = fs;
        @(negedge clk);
        wr_en = 1'b0; frame_start = 1'b0;
    endtask

    task automatic frame();
        @(negedge clk) frame_start = 1'b1;
        @(negedge clk) frame_start = 1'b0;
    endtask

    // drive a pixel and wait out the two-cycle pipeline
    task automatic pix(input int h, input int v);
        @(negedge clk);
        h_cnt = 10'(h); v_cnt = 10'(v);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({enable_target, target_idx, update_pending, blink_phase} !== 5'b0) begin
            errs++; $display("FAIL reset_outputs: got %b want 00000", {enable_target, target_idx, update_pending, blink_phase});
        end
        rst = 1'b0;
        pix(0, 0);
        checks++;
        if (enable_target !== 1'b0) begin errs++; $display("FAIL reset_pixel00: en=%b want 0", enable_target); end
    endtask

    task automatic test_single();
        logic exp;
        wr(0, 100, 50, 1'b1, 1'b0, 1'b0);
        checks++;
        if (update_pending !== 1'b1) begin errs++; $display("FAIL single_pending_set: got %b want 1", update_pending); end
        pix(110, 60);
        checks++;
        if (enable_target !== 1'b0) begin errs++; $display("FAIL single_precommit: en=%b want 0", enable_target); end
        frame();
        checks++;
        if (update_pending !== 1'b0) begin errs++; $display("FAIL single_pending_clr: got %b want 0", update_pending); end
        // row sweep: output at each negedge belongs to the pixel driven two negedges earlier
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                exp = (95 + i - 2 >= 100) && (95 + i - 2 <= 147);
                checks++;
                if (enable_target !== exp || target_idx !== 2'd0) begin
                    errs++; $display("FAIL single_sweep h=%0d: en=%b idx=%0d want en=%b idx=0", 95 + i - 2, enable_target, target_idx, exp);
                end
            end
            h_cnt = 10'(95 + i); v_cnt = 10'd60;
        end
        begin
            int t [8][3] = '{'{99, 60, 0}, '{100, 60, 1}, '{147, 60, 1}, '{148, 60, 0},
                             '{120, 49, 0}, '{120, 50, 1}, '{120, 97, 1}, '{120, 98, 0}};
            for (int k = 0; k < 8; k++) begin
                pix(t[k][0], t[k][1]);
                checks++;
                if (enable_target !== 1'(t[k][2])) begin
                    errs++; $display("FAIL single_edge (%0d,%0d): en=%b want %0d", t[k][0], t[k][1], enable_target, t[k][2]);
                end
            end
        end
    endtask

    task automatic test_priority();
        int t [5][4] = '{'{125, 65, 1, 1}, '{112, 56, 1, 2}, '{160, 100, 1, 1}, '{130, 70, 1, 0}, '{125, 65, 1, 0}};
        wr(0, 100, 50, 1'b0, 1'b0, 1'b0);
        wr(1, 120, 60, 1'b1, 1'b0, 1'b0);
        wr(2, 110, 55, 1'b1, 1'b0, 1'b0);
        frame();
        for (int k = 0; k < 5; k++) begin
            if (k == 3) begin wr(0, 100, 50, 1'b1, 1'b0, 1'b0); frame(); end
            pix(t[k][0], t[k][1]);
            checks++;
            if (enable_target !== 1'(t[k][2]) || target_idx !== 2'(t[k][3])) begin
                errs++; $display("FAIL priority (%0d,%0d): en=%b idx=%0d want en=%0d idx=%0d",
                                 t[k][0], t[k][1], enable_target, target_idx, t[k][2], t[k][3]);
            end
        end
    endtask

    task automatic test_clip();
        int t [6][3] = '{'{1000, 1000, 1}, '{1023, 1023, 1}, '{999, 1010, 0}, '{0, 0, 0}, '{1010, 10, 0}, '{10, 1010, 0}};
        wr(3, 1000, 1000, 1'b1, 1'b0, 1'b0);
        frame();
        for (int k = 0; k < 6; k++) begin
            pix(t[k][0], t[k][1]);
            checks++;
            if (enable_target !== 1'(t[k][2]) || (t[k][2] == 1 && target_idx !== 2'd3)) begin
                errs++; $display("FAIL clip (%0d,%0d): en=%b idx=%0d want en=%0d idx=3", t[k][0], t[k][1], enable_target, target_idx, t[k][2]);
            end
        end
    endtask

    task automatic test_back_to_back();
        wr(0, 200, 200, 1'b1, 1'b0, 1'b1);
        checks++;
        if (update_pending !== 1'b1) begin errs++; $display("FAIL b2b_pending_held: got %b want 1", update_pending); end
        pix(110, 60);
        checks++;
        if (enable_target !== 1'b1 || target_idx !== 2'd0) begin
            errs++; $display("FAIL b2b_old_pos: en=%b idx=%0d want en=1 idx=0", enable_target, target_idx);
        end
        pix(210, 210);
        checks++;
        if (enable_target !== 1'b0) begin errs++; $display("FAIL b2b_new_early: en=%b want 0", enable_target); end
        frame();
        checks++;
        if (update_pending !== 1'b0) begin errs++; $display("FAIL b2b_pending_clr: got %b want 0", update_pending); end
        pix(210, 210);
        checks++;
        if (enable_target !== 1'b1 || target_idx !== 2'd0) begin
            errs++; $display("FAIL b2b_new_pos: en=%b idx=%0d want en=1 idx=0", enable_target, target_idx);
        end
        pix(110, 60);
        checks++;
        if (enable_target !== 1'b1 || target_idx !== 2'd2) begin
            errs++; $display("FAIL b2b_vacated: en=%b idx=%0d want en=1 idx=2", enable_target, target_idx);
        end
    endtask

    task automatic test_blink();
        logic ph;
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        wr(0, 100, 50, 1'b1, 1'b1, 1'b0);
        wr(1, 300, 300, 1'b1, 1'b0, 1'b0);
        for (int p = 1; p <= 8; p++) begin
            frame();
            ph = 1'((p / B) % 2);
            checks++;
            if (blink_phase !== ph) begin errs++; $display("FAIL blink_phase pulse %0d: got %b want %b", p, blink_phase, ph); end
            pix(110, 60);
            checks++;
            if (enable_target !== ph) begin errs++; $display("FAIL blink_target pulse %0d: en=%b want %b", p, enable_target, ph); end
            pix(310, 310);
            checks++;
            if (enable_target !== 1'b1 || target_idx !== 2'd1) begin
                errs++; $display("FAIL blink_steady pulse %0d: en=%b idx=%0d want en=1 idx=1", p, enable_target, target_idx);
            end
        end
    endtask

    task automatic test_reset_mid();
        wr(2, 400, 400, 1'b1, 1'b0, 1'b0);
        pix(310, 310);
        checks++;
        if (enable_target !== 1'b1 || update_pending !== 1'b1) begin
            errs++; $display("FAIL rstmid_before: en=%b pend=%b want 1 1", enable_target, update_pending);
        end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({enable_target, target_idx, update_pending, blink_phase} !== 5'b0) begin
            errs++; $display("FAIL rstmid_async: got %b want 00000", {enable_target, target_idx, update_pending, blink_phase});
        end
        @(negedge clk) rst = 1'b0;
        frame();
        pix(310, 310);
        checks++;
        if (enable_target !== 1'b0 || update_pending !== 1'b0) begin
            errs++; $display("FAIL rstmid_after: en=%b pend=%b want 0 0", enable_target, update_pending);
        end
        pix(410, 410);
        checks++;
        if (enable_target !== 1'b0) begin errs++; $display("FAIL rstmid_discard: en=%b want 0", enable_target); end
        wr(0, 300, 300, 1'b1, 1'b0, 1'b0);
        frame();
        pix(310, 310);
        checks++;
        if (enable_target !== 1'b1 || target_idx !== 2'd0) begin
            errs++; $display("FAIL rstmid_rewrite: en=%b idx=%0d want en=1 idx=0", enable_target, target_idx);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_clip();
        test_back_to_back();
        test_blink();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/target_display.md
# target_display

Parametrised multi-target renderer for the VGA pipeline. It replaces the single-ball window check with N_TGT independently positioned square targets. Each target has its own visibility and blink control. Position updates are double-buffered so they only take effect at frame boundaries. The block sits between the VGA timing generator (25 MHz pixel clock, h_cnt/v_cnt) and the colour mux. It reports whether the current pixel is covered by a target and which target covers it.

## Interface
- N_TGT, 4: number of targets; legal range 1..16.
- SIZE, 48: target edge length in pixels; legal range 1..512.
- BLINK_FRAMES, 15: frames per blink half-period; legal range ≥1.
- IDX_W, max(1, clog2(N_TGT)): target index width; derived, not overridden.

- clk  in  1  25 MHz VGA pixel clock.
- rst  in  1  Asynchronous reset, active high.
- h_cnt  in  10  Current horizontal pixel counter.
- v_cnt  in  10  Current vertical pixel counter.
- frame_start  in  1  One-cycle pulse per frame, asserted during vertical blanking. Commits the shadow registers.
- wr_en  in  1  Write strobe; one target write per cycle.
- wr_idx  in  IDX_W  Target selected by the write. Writes with wr_idx ≥ N_TGT are ignored.
- wr_x  in  10  New left edge.
- wr_y  in  10  New top edge.
- wr_vis  in  1  New visibility flag.
- wr_blink  in  1  New blink-enable flag.
- enable_target  out  1  Current pixel is covered by at least one shown target.
- target_idx  out  IDX_W  Lowest-index shown target that covers the pixel. Forced to 0 when enable_target is 0.
- update_pending  out  1  At least one shadow write is waiting for commit.
- blink_phase  out  1  Current blink phase. Blinking targets are shown only while this is 1.

## Operation
- Each target has shadow registers (x, y, vis, blink) and active registers of the same fields.
- Writes go only to the shadow registers.
- On frame_start, all shadow registers are copied to the active registers simultaneously.
- Rendering uses only the active registers.
- If wr_en and frame_start occur in the same cycle:
  - The commit copies the pre-write shadow contents.
  - The write lands in the shadow registers.
  - The write is committed at the next frame_start.
  - update_pending stays 1.
- update_pending:
  - Set by any accepted write.
  - Cleared by frame_start, unless an accepted write occurs in the same cycle.
- Coverage of target i: active x_i ≤ h_cnt < x_i + SIZE, and active y_i ≤ v_cnt < y_i + SIZE.
  - The sums are computed 11 bits wide, so there is no wrap-around.
  - A target extending past 1023 is clipped and never wraps to column or row 0.
- Target i is shown when vis_i = 1 and (blink_i = 0 or blink_phase = 1).
- Priority: when several shown targets cover a pixel, the lowest index wins.
- Blink logic:
  - A frame counter counts frame_start pulses from 0 to BLINK_FRAMES−1.
  - On the pulse that would reach BLINK_FRAMES, the counter returns to 0 and blink_phase toggles.
  - BLINK_FRAMES = 1 toggles the phase on every frame_start.

## Timing
- Two-stage pipeline; output latency is 2 clk cycles from h_cnt/v_cnt.
  - Stage 1 registers the per-target x and y comparisons.
  - Stage 2 registers the shown-mask AND, priority encode, enable_target and target_idx.
  - Downstream logic delays colour selection to match.
- A commit on cycle t:
  - Affects comparisons made with h_cnt/v_cnt sampled at cycle t+1 or later.
  - Visible at the outputs from cycle t+3.
- The blink_phase toggle on frame_start cycle t is registered at t+1 and affects stage-2 masking from t+1.
- Reset values:
  - All shadow and active x, y, vis and blink fields are 0.
  - The frame counter is 0 and blink_phase is 0.
  - Both pipeline stages are cleared; enable_target = 0, target_idx = 0, update_pending = 0.
- Reset mid-frame clears everything immediately and asynchronously. Pending writes are discarded.
- There is no backpressure: every in-range write is accepted in the cycle it is presented.

## Test plan
- Reset, then write target 0 at (100, 50) with vis = 1, then pulse frame_start. Sweep h_cnt and v_cnt.
  - Before frame_start: enable_target = 0 everywhere.
  - After commit: enable_target = 1 exactly for h ∈ [100, 147] and v ∈ [50, 97], with target_idx = 0.
  - Output appears 2 cycles after the matching counters.
- Write target 1 at (120, 60) and target 2 at (110, 55), both visible, then commit.
  - Pixel (125, 65): target_idx = 1.
  - Pixel (112, 56): target_idx = 2.
  - Pixel (130, 70) with target 0 also visible at (100, 50): target_idx = 0.
- Write target 3 at (1000, 1000) with vis = 1, then commit.
  - enable_target = 1 for h and v ∈ [1000, 1023].
  - Pixel (0, 0): enable_target = 0; no wrap.
- Apply wr_en for target 0 at (200, 200) in the same cycle as frame_start.
  - The target stays at its old position for that frame.
  - update_pending remains 1.
  - The new position is active after the next frame_start, and update_pending then goes to 0.
- BLINK_FRAMES = 2; target 0 has vis = 1 and blink = 1. Issue 8 frame_start pulses.
  - blink_phase toggles after pulses 2, 4, 6 and 8.
  - enable_target over the target area follows blink_phase.
  - A non-blinking visible target is shown in every frame.
- Assert rst mid-frame with targets active and a write pending.
  - All outputs go to 0 immediately.
  - After release, there is no coverage until new writes are committed.
